// File: rtl/gecko_writeback_tracker_pkg.sv
// Shared types for the writeback tracker: counter status classes and tracker states.
// The optional protocol checker in the top is enabled by GECKO_WRITEBACK_CHECK_EN.
package gecko_writeback_tracker_pkg;

    localparam int unsigned GECKO_COUNTER_WIDTH = 2;
    localparam int unsigned GECKO_NUM_REGS      = 32;
    localparam int unsigned GECKO_REG_AW        = 5;

    typedef logic [GECKO_COUNTER_WIDTH-1:0] gecko_reg_status_t;

    typedef enum logic [1:0] {
        GECKO_REG_STATUS_VALID   = 2'd0,
        GECKO_REG_STATUS_PENDING = 2'd1,
        GECKO_REG_STATUS_FULL    = 2'd2
    } gecko_reg_status_e;

    typedef enum logic {
        GECKO_WB_TRACKER_INIT = 1'b0,
        GECKO_WB_TRACKER_RUN  = 1'b1
    } gecko_wb_tracker_state_e;

    function automatic gecko_reg_status_e gecko_reg_classify(input gecko_reg_status_t cnt);
        if (cnt == '0)
            return GECKO_REG_STATUS_VALID;
        else if (&cnt)
            return GECKO_REG_STATUS_FULL;
        else
            return GECKO_REG_STATUS_PENDING;
    endfunction

endpackage

// File: rtl/gecko_reg_counter.sv
// Saturating up/down outstanding-write counter for one architectural register.
// Requests that would overflow or underflow are dropped; simultaneous inc/dec cancel.
module gecko_reg_counter
    import gecko_writeback_tracker_pkg::*;
#(
    parameter int unsigned W = GECKO_COUNTER_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_req,
    input  logic         dec_req,
    output logic [W-1:0] count
);

    gecko_reg_status_e status;
    logic              inc;
    logic              dec;

    always_comb begin
        status = GECKO_REG_STATUS_PENDING;
        if (count == '0)
            status = GECKO_REG_STATUS_VALID;
        else if (&count)
            status = GECKO_REG_STATUS_FULL;
    end

    assign inc = inc_req && (status != GECKO_REG_STATUS_FULL);
    assign dec = dec_req && (status != GECKO_REG_STATUS_VALID);

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (inc && !dec)
            count <= count + W'(1);
        else if (dec && !inc)
            count <= count - W'(1);
    end

endmodule

// File: rtl/gecko_writeback_tracker.sv
// Writeback-side register file plus per-register outstanding-write counters exported to decode.
// Define GECKO_WRITEBACK_CHECK_EN to build the sticky protocol checker (check_error/check_addr).
module gecko_writeback_tracker
    import gecko_writeback_tracker_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = GECKO_COUNTER_WIDTH,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    reserve_valid,
    input  logic [GECKO_REG_AW-1:0]                 reserve_addr,
    input  logic                                    retire_valid,
    output logic                                    retire_ready,
    input  logic [GECKO_REG_AW-1:0]                 retire_addr,
    input  logic [DATA_WIDTH-1:0]                   retire_value,
    input  logic [GECKO_REG_AW-1:0]                 rs1_addr,
    input  logic [GECKO_REG_AW-1:0]                 rs2_addr,
    output logic [DATA_WIDTH-1:0]                   rs1_value,
    output logic [DATA_WIDTH-1:0]                   rs2_value,
    output logic [GECKO_NUM_REGS*COUNTER_WIDTH-1:0] reg_status,
    output logic                                    init_done,
    output logic                                    check_error,
    output logic [GECKO_REG_AW-1:0]                 check_addr
);

    localparam int unsigned AW = GECKO_REG_AW;

    gecko_wb_tracker_state_e state;
    logic [AW-1:0]           sweep_idx;
    logic [DATA_WIDTH-1:0]   regs [GECKO_NUM_REGS];
    logic                    retire_hs;
    logic                    reserve_en;
    logic [DATA_WIDTH-1:0]   rs1_next;
    logic [DATA_WIDTH-1:0]   rs2_next;

    assign retire_hs  = retire_valid && retire_ready;
    assign reserve_en = reserve_valid && (state == GECKO_WB_TRACKER_RUN);

    // x0 has no counter; its status slice is hardwired to VALID.
    assign reg_status[COUNTER_WIDTH-1:0] = '0;

    for (genvar r = 1; r < GECKO_NUM_REGS; r++) begin : g_cnt
        gecko_reg_counter #(
            .W (COUNTER_WIDTH)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .inc_req (reserve_en && (reserve_addr == AW'(r))),
            .dec_req (retire_hs && (retire_addr == AW'(r))),
            .count   (reg_status[r*COUNTER_WIDTH +: COUNTER_WIDTH])
        );
    end

    // Write-first read ports; x0 always reads zero.
    always_comb begin
        rs1_next = '0;
        rs2_next = '0;
        if (rs1_addr != '0)
            rs1_next = (retire_hs && (retire_addr == rs1_addr)) ? retire_value : regs[rs1_addr];
        if (rs2_addr != '0)
            rs2_next = (retire_hs && (retire_addr == rs2_addr)) ? retire_value : regs[rs2_addr];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= GECKO_WB_TRACKER_INIT;
            sweep_idx    <= '0;
            init_done    <= 1'b0;
            retire_ready <= 1'b0;
            rs1_value    <= '0;
            rs2_value    <= '0;
        end else begin
            case (state)
                GECKO_WB_TRACKER_INIT: begin
                    sweep_idx <= sweep_idx + AW'(1);
                    rs1_value <= '0;
                    rs2_value <= '0;
                    if (sweep_idx == AW'(GECKO_NUM_REGS - 1)) begin
                        state        <= GECKO_WB_TRACKER_RUN;
                        init_done    <= 1'b1;
                        retire_ready <= 1'b1;
                    end
                end
                GECKO_WB_TRACKER_RUN: begin
                    rs1_value <= rs1_next;
                    rs2_value <= rs2_next;
                end
                default: state <= GECKO_WB_TRACKER_INIT;
            endcase
        end
    end

    // Storage is not reset; the INIT sweep clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == GECKO_WB_TRACKER_INIT)
                regs[sweep_idx] <= '0;
            else if (retire_hs && (retire_addr != '0))
                regs[retire_addr] <= retire_value;
        end
    end

`ifdef GECKO_WRITEBACK_CHECK_EN
    logic [COUNTER_WIDTH-1:0] rsv_cnt;
    logic [COUNTER_WIDTH-1:0] ret_cnt;
    logic                     rsv_err;
    logic                     ret_err;

    assign rsv_cnt = reg_status[reserve_addr*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign ret_cnt = reg_status[retire_addr*COUNTER_WIDTH +: COUNTER_WIDTH];
    assign rsv_err = reserve_en && (reserve_addr != '0) && (&rsv_cnt);
    assign ret_err = retire_hs && (retire_addr != '0) && (ret_cnt == '0)
                     && !(reserve_en && (reserve_addr == retire_addr));

    always_ff @(posedge clk) begin
        if (!rst) begin
            check_error <= 1'b0;
            check_addr  <= '0;
        end else if (!check_error && (rsv_err || ret_err)) begin
            check_error <= 1'b1;
            check_addr  <= rsv_err ? reserve_addr : retire_addr;
`ifndef SYNTHESIS
            $error("gecko_writeback_tracker: protocol error on x%0d",
                   rsv_err ? reserve_addr : retire_addr);
`endif
        end
    end
`else
    assign check_error = 1'b0;
    assign check_addr  = '0;
`endif

endmodule

// File: tb/tb_gecko_writeback_tracker.sv
// Directed self-checking bench for gecko_writeback_tracker (default COUNTER_WIDTH=2, DATA_WIDTH=32).
module tb_gecko_writeback_tracker;

    logic        clk;
    logic        rst;
    logic        reserve_valid;
    logic [4:0]  reserve_addr;
    logic        retire_valid;
    logic        retire_ready;
    logic [4:0]  retire_addr;
    logic [31:0] retire_value;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [63:0] reg_status;
    logic        init_done;
    logic        check_error;
    logic [4:0]  check_addr;

    int checks = 0;
    int errors = 0;

    gecko_writeback_tracker dut (
        .clk           (clk),
        .rst           (rst),
        .reserve_valid (reserve_valid),
        .reserve_addr  (reserve_addr),
        .retire_valid  (retire_valid),
        .retire_ready  (retire_ready),
        .retire_addr   (retire_addr),
        .retire_value  (retire_value),
        .rs1_addr      (rs1_addr),
        .rs2_addr      (rs2_addr),
        .rs1_value     (rs1_value),
        .rs2_value     (rs2_value),
        .reg_status    (reg_status),
        .init_done     (init_done),
        .check_error   (check_error),
        .check_addr    (check_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] cnt(input int r);
        return reg_status[r*2 +: 2];
    endfunction

    initial begin
        rst           = 1'b0;
        reserve_valid = 1'b0;
        reserve_addr  = 5'd0;
        retire_valid  = 1'b0;
        retire_addr   = 5'd0;
        retire_value  = 32'd0;
        rs1_addr      = 5'd5;
        rs2_addr      = 5'd31;

        // reset state
        step();
        check("rst_init_done", 64'(init_done), 64'd0);
        check("rst_ready", 64'(retire_ready), 64'd0);
        check("rst_rs1", 64'(rs1_value), 64'd0);
        check("rst_rs2", 64'(rs2_value), 64'd0);
        check("rst_status", reg_status, 64'd0);
        check("rst_check_error", 64'(check_error), 64'd0);
        check("rst_check_addr", 64'(check_addr), 64'd0);

        // INIT sweep: 32 edges, reserves ignored
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            reserve_valid = (i == 10);
            reserve_addr  = 5'd6;
            step();
            check("init_done", 64'(init_done), (i == 32) ? 64'd1 : 64'd0);
            check("init_ready", 64'(retire_ready), (i == 32) ? 64'd1 : 64'd0);
            check("init_rs1", 64'(rs1_value), 64'd0);
        end
        reserve_valid = 1'b0;
        check("init_reserve_ignored", 64'(cnt(6)), 64'd0);
        step();
        check("post_init_rs1_x5", 64'(rs1_value), 64'd0);
        check("post_init_rs2_x31", 64'(rs2_value), 64'd0);

        // saturate x5
        reserve_valid = 1'b1;
        reserve_addr  = 5'd5;
        step();
        check("x5_cnt1", 64'(cnt(5)), 64'd1);
        step();
        check("x5_cnt2", 64'(cnt(5)), 64'd2);
        step();
        check("x5_cnt3_full", 64'(cnt(5)), 64'd3);
        step();
        check("x5_cnt_sat", 64'(cnt(5)), 64'd3);
`ifdef GECKO_WRITEBACK_CHECK_EN
        check("x5_check_error", 64'(check_error), 64'd1);
        check("x5_check_addr", 64'(check_addr), 64'd5);
`else
        check("x5_check_error", 64'(check_error), 64'd0);
        check("x5_check_addr", 64'(check_addr), 64'd0);
`endif

        // x7: simultaneous reserve and retire leave counter unchanged
        reserve_addr = 5'd7;
        step();
        check("x7_cnt1", 64'(cnt(7)), 64'd1);
        retire_valid = 1'b1;
        retire_addr  = 5'd7;
        retire_value = 32'hDEADBEEF;
        step();
        check("x7_cnt_hold", 64'(cnt(7)), 64'd1);
        reserve_valid = 1'b0;
        retire_valid  = 1'b0;
        rs1_addr      = 5'd7;
        step();
        check("x7_read", 64'(rs1_value), 64'hDEADBEEF);

        // x9: bypass on same-cycle retire and read
        reserve_valid = 1'b1;
        reserve_addr  = 5'd9;
        step();
        check("x9_cnt1", 64'(cnt(9)), 64'd1);
        reserve_valid = 1'b0;
        retire_valid  = 1'b1;
        retire_addr   = 5'd9;
        retire_value  = 32'h1234;
        rs2_addr      = 5'd9;
        step();
        check("x9_bypass", 64'(rs2_value), 64'h1234);
        check("x9_cnt0", 64'(cnt(9)), 64'd0);
        retire_valid = 1'b0;
        step();
        check("x9_stored", 64'(rs2_value), 64'h1234);

        // x0: writes and reserves have no effect
        retire_valid  = 1'b1;
        retire_addr   = 5'd0;
        retire_value  = 32'hFFFFFFFF;
        reserve_valid = 1'b1;
        reserve_addr  = 5'd0;
        rs1_addr      = 5'd0;
        step();
        check("x0_bypass_zero", 64'(rs1_value), 64'd0);
        check("x0_cnt", 64'(cnt(0)), 64'd0);
        retire_valid  = 1'b0;
        reserve_valid = 1'b0;
        rs2_addr      = 5'd0;
        step();
        check("x0_read1", 64'(rs1_value), 64'd0);
        check("x0_read2", 64'(rs2_value), 64'd0);
`ifndef GECKO_WRITEBACK_CHECK_EN
        check("x0_no_error", 64'(check_error), 64'd0);
`endif

        // mid-RUN reset
        reserve_valid = 1'b1;
        reserve_addr  = 5'd3;
        step();
        check("x3_cnt1", 64'(cnt(3)), 64'd1);
        reserve_valid = 1'b0;
        rst           = 1'b0;
        rs1_addr      = 5'd7;
        step();
        check("mid_rst_status", reg_status, 64'd0);
        check("mid_rst_init_done", 64'(init_done), 64'd0);
        check("mid_rst_ready", 64'(retire_ready), 64'd0);
        check("mid_rst_rs1", 64'(rs1_value), 64'd0);
        check("mid_rst_check_error", 64'(check_error), 64'd0);
        rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            // last INIT cycle: retire/reserve must be ignored (ready still low)
            retire_valid  = (i == 32);
            retire_addr   = 5'd4;
            retire_value  = 32'hAAAA5555;
            reserve_valid = (i == 32);
            reserve_addr  = 5'd4;
            step();
            check("reinit_done", 64'(init_done), (i == 32) ? 64'd1 : 64'd0);
        end
        retire_valid  = 1'b0;
        reserve_valid = 1'b0;
        check("reinit_x4_cnt", 64'(cnt(4)), 64'd0);
        rs1_addr = 5'd4;
        rs2_addr = 5'd7;
        step();
        check("reinit_x4_read", 64'(rs1_value), 64'd0);
        check("reinit_x7_cleared", 64'(rs2_value), 64'd0);
        rs1_addr = 5'd3;
        step();
        check("reinit_x3_read", 64'(rs1_value), 64'd0);
        check("reinit_x3_cnt", 64'(cnt(3)), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
